// File: rtl/logic_calc_if.sv
// ============================================================================
//  Module   : logic_calc_if
//  Brief    : Request/response bundle for logic_calc (operands in, result out).
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface logic_calc_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
`ifdef LOGIC_CALC_ZERO_EN
    logic             zero;

    modport master (
        output in_valid, A, B, op, out_ready,
        input  in_ready, out_valid, result, zero
    );
    modport slave (
        input  in_valid, A, B, op, out_ready,
        output in_ready, out_valid, result, zero
    );
`else
    modport master (
        output in_valid, A, B, op, out_ready,
        input  in_ready, out_valid, result
    );
    modport slave (
        input  in_valid, A, B, op, out_ready,
        output in_ready, out_valid, result
    );
`endif
endinterface

`default_nettype wire

// File: rtl/logic_calc.sv
// ============================================================================
//  Module   : logic_calc
//  Brief    : Bitwise AND/OR/XOR/NOR unit computing SLICE bits per cycle.
//             Optional zero flag enabled by macro LOGIC_CALC_ZERO_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module logic_calc #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  wire logic      clock,
    input  wire logic      reset_n,
    logic_calc_if.slave    bus
);

    localparam int N     = WIDTH / SLICE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] slice_cnt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [1:0]       op_reg;
    logic [WIDTH-1:0] result_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;

    logic [31:0]      base;
    logic [SLICE-1:0] a_slice;
    logic [SLICE-1:0] b_slice;
    logic [SLICE-1:0] slice_val;
    logic [WIDTH-1:0] next_result;

    assign base = 32'(slice_cnt) * 32'(SLICE);

    // Result word as it will look after this cycle's slice is written.
    always_comb begin
        a_slice   = a_reg[base +: SLICE];
        b_slice   = b_reg[base +: SLICE];
        slice_val = '0;
        case (op_reg)
            2'b00:   slice_val = a_slice & b_slice;
            2'b01:   slice_val = a_slice | b_slice;
            2'b10:   slice_val = a_slice ^ b_slice;
            default: slice_val = ~(a_slice | b_slice);
        endcase
        next_result                = result_reg;
        next_result[base +: SLICE] = slice_val;
    end

`ifdef LOGIC_CALC_ZERO_EN
    logic zero_reg;
    assign bus.zero = zero_reg;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            slice_cnt     <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            op_reg        <= '0;
            result_reg    <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
`ifdef LOGIC_CALC_ZERO_EN
            zero_reg      <= 1'b1;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_reg        <= bus.A;
                        b_reg        <= bus.B;
                        op_reg       <= bus.op;
                        result_reg   <= '0;
                        slice_cnt    <= '0;
                        in_ready_reg <= 1'b0;
                        state        <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    result_reg <= next_result;
                    if (slice_cnt == LAST_SLICE) begin
                        out_valid_reg <= 1'b1;
                        state         <= S_DONE;
`ifdef LOGIC_CALC_ZERO_EN
                        zero_reg      <= (next_result == '0);
`endif
                    end else begin
                        slice_cnt <= slice_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    // A request arriving with out_ready waits for the next IDLE edge.
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state         <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.result    = result_reg;

endmodule

`default_nettype wire

// File: tb/tb_logic_calc.sv
// ============================================================================
//  Module   : tb_logic_calc
//  Brief    : Randomized self-checking bench for logic_calc with a word-level model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_logic_calc;

    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic_calc_if #(.WIDTH(32)) bus ();
    logic_calc_if #(.WIDTH(16)) bus2 ();

    logic_calc #(.WIDTH(32), .SLICE(8)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus.slave)
    );

    logic_calc #(.WIDTH(16), .SLICE(16)) dut_wide (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus2.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Word-level model: a request occupies the unit for LAT edges, then waits to be retired.
    logic [31:0] m_res  = '0;
    logic [31:0] m_pend = '0;
    int          m_left = 0;
    bit          m_done = 1'b0;
    bit          m_zero = 1'b1;
    bit          chk_en = 1'b0;

    function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] o);
        case (o)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_left = 0; m_done = 1'b0; m_res = '0; m_zero = 1'b1;
        end else if (m_done) begin
            if (bus.out_ready) m_done = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1'b1;
                m_res  = m_pend;
                m_zero = (m_pend == 0);
            end
        end else if (bus.in_valid) begin
            m_pend = ref_op(bus.A, bus.B, bus.op);
            m_res  = '0;
            m_left = LAT;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", 32'(bus.in_ready), 32'(m_left == 0 && !m_done));
            check("out_valid", 32'(bus.out_valid), 32'(m_done));
            if (m_left == 0) check("result", bus.result, m_res);
`ifdef LOGIC_CALC_ZERO_EN
            check("zero", 32'(bus.zero), 32'(m_zero));
`endif
        end
    end

    task automatic randomize_inputs();
        bus.A  = $urandom;
        bus.B  = $urandom;
        bus.op = 2'($urandom_range(0, 3));
    endtask

    // Present a request and return just after the accept edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
        int w;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.A = a; bus.B = b; bus.op = o; bus.out_ready = 1'b0;
        w = 0;
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("accept_timeout", 32'(w >= 50), 32'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        randomize_inputs();
    endtask

    // Wait for the result while disturbing the ports, hold it for stall cycles, then retire.
    task automatic finish(input int stall, output logic [31:0] res, output int lat);
        bit got;
        lat = 0; got = 1'b0;
        while (!got && lat < 50) begin
            @(posedge clk); #1;
            lat++;
            if (bus.out_valid) got = 1'b1;
            else begin
                bus.in_valid  = 1'($urandom_range(0, 1));
                bus.out_ready = 1'($urandom_range(0, 1));
                randomize_inputs();
            end
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        res = bus.result;
        repeat (stall) begin
            @(negedge clk);
            check("held_result", bus.result, res);
            bus.in_valid = 1'($urandom_range(0, 1));
            randomize_inputs();
        end
        @(negedge clk);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    logic [31:0] res;
    int          lat;
    logic [31:0] ra, rb;
    logic [1:0]  ro;
    logic [31:0] exp_dir [4];

    initial begin
        exp_dir[0] = 32'h00F0_1234; exp_dir[1] = 32'hFFF0_FFFF;
        exp_dir[2] = 32'hFF00_EDCB; exp_dir[3] = 32'h000F_0000;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.A = '0; bus.B = '0; bus.op = '0;
        bus2.in_valid = 1'b0; bus2.out_ready = 1'b0; bus2.A = '0; bus2.B = '0; bus2.op = '0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", bus.result, 32'd0);
`ifdef LOGIC_CALC_ZERO_EN
        check("rst_zero", 32'(bus.zero), 32'd1);
`endif

        for (int i = 0; i < 4; i++) begin
            send(32'hF0F0_1234, 32'h0FF0_FFFF, 2'(i));
            finish(i, res, lat);
            check("dir_latency", 32'(lat), 32'(LAT));
            check("dir_result", res, exp_dir[i]);
        end

        send(32'hAAAA_AAAA, 32'h5555_5555, 2'b00);
        finish(5, res, lat);
        check("zero_result", res, 32'd0);

        // Retire and new request in the same cycle: acceptance waits one edge.
        send(32'h1234_5678, 32'hFFFF_0000, 2'b10);
        while (!bus.out_valid) @(negedge clk);
        bus.in_valid = 1'b1; bus.A = 32'h0000_FFFF; bus.B = 32'h00FF_00FF; bus.op = 2'b01;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("chain_not_accepted", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        check("chain_accepted", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        finish(1, res, lat);
        check("chain_result", res, 32'h00FF_FFFF);

        // Reset sampled in the second BUSY cycle aborts the operation.
        send(32'hDEAD_BEEF, 32'h1111_1111, 2'b01);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_result", bus.result, 32'd0);
        repeat (6) begin
            @(negedge clk);
            check("abort_no_valid", 32'(bus.out_valid), 32'd0);
        end
        send(32'hCAFE_0001, 32'h0F0F_0F0F, 2'b11);
        finish(0, res, lat);
        check("post_abort_result", res, ref_op(32'hCAFE_0001, 32'h0F0F_0F0F, 2'b11));

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ~ra;
                default: rb = $urandom;
            endcase
            ro = 2'($urandom_range(0, 3));
            send(ra, rb, ro);
            finish(int'($urandom_range(0, 4)), res, lat);
            check("rand_latency", 32'(lat), 32'(LAT));
            check("rand_result", res, ref_op(ra, rb, ro));
        end

        // Single-slice instance completes one edge after acceptance.
        @(negedge clk);
        check("wide_in_ready", 32'(bus2.in_ready), 32'd1);
        bus2.in_valid = 1'b1; bus2.A = 16'h00FF; bus2.B = 16'h0F0F; bus2.op = 2'b10;
        @(posedge clk); #1;
        bus2.in_valid = 1'b0;
        check("wide_busy", 32'(bus2.out_valid), 32'd0);
        @(posedge clk); #1;
        check("wide_valid", 32'(bus2.out_valid), 32'd1);
        check("wide_result", 32'(bus2.result), 32'h0000_0FF0);
        bus2.out_ready = 1'b1;
        @(posedge clk); #1;
        bus2.out_ready = 1'b0;
        check("wide_retired", 32'(bus2.out_valid), 32'd0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/logic_calc.md
LOGIC_CALC -- requirements
Module: logic_calc

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL be a positive multiple of SLICE.
REQ-002 Parameter SLICE, default 8, bits processed per cycle; SHALL satisfy 1 <= SLICE <= WIDTH.
REQ-003 clock  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  synchronous active-low reset, sampled on rising edge of clock.
REQ-005 in_valid  input  1  request strobe; A, B, op valid while high.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 A  input  WIDTH  operand A.
REQ-008 B  input  WIDTH  operand B.
REQ-009 op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  WIDTH  registered bitwise result.
REQ-013 zero  output  1  result == 0; present only with LOGIC_CALC_ZERO_EN (REQ-031).

Function
REQ-014 FSM states IDLE, BUSY, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-015 Accept: IDLE with in_valid = 1 at rising edge -> latch A, B, op into internal registers, clear result to 0, clear slice counter to 0, go to BUSY.
REQ-016 IDLE with in_valid = 0 -> stay IDLE, result holds last value.
REQ-017 BUSY: each cycle compute result[k*SLICE +: SLICE] = op(A_reg, B_reg) slice k, k = slice counter, then increment counter.
REQ-018 BUSY -> DONE on the edge that writes slice N-1, N = WIDTH/SLICE; counter does not wrap past N-1.
REQ-019 Latency: out_valid rises exactly N cycles after the accept edge (N = 4 at defaults); SLICE = WIDTH gives latency 1.
REQ-020 Port A, B, op, in_valid changes after acceptance SHALL NOT affect the in-flight result.
REQ-021 in_valid during BUSY or DONE is ignored (not queued); requester holds in_valid until it sees in_ready.
REQ-022 DONE: result and out_valid held stable until out_ready = 1; then go IDLE on that edge.
REQ-023 DONE with out_ready = 1 and in_valid = 1 same cycle: only the result is retired; the new request is accepted no earlier than the following edge in IDLE.
REQ-024 out_ready outside DONE is ignored.
REQ-025 NOR slice = bitwise inversion of OR slice; no carries or cross-slice dependency.

Reset
REQ-026 reset_n = 0 at a rising edge -> state IDLE, counter 0, operand/op registers 0, result 0, out_valid 0, in_ready 1, zero 1 (if present).
REQ-027 Reset during BUSY or DONE aborts the operation; no out_valid pulse for it after reset release.
REQ-028 First request accepted on the first edge with reset_n = 1 and in_valid = 1.

Configuration
REQ-029 Macro LOGIC_CALC_ZERO_EN selects the zero flag feature.
REQ-030 Without LOGIC_CALC_ZERO_EN: port zero and its logic are absent; all other behaviour identical.
REQ-031 With LOGIC_CALC_ZERO_EN: zero is a register updated on the BUSY->DONE edge to (final result == 0), held through DONE and IDLE, 1 after reset.

Verification
REQ-032 Defaults, A=32'hF0F0_1234, B=32'h0FF0_FFFF, op=00 -> out_valid after 4 cycles, result=32'h00F0_1234, zero=0.
REQ-033 op=01/10/11 with same operands -> result 32'hFFF0_FFFF / 32'hFF00_EDCB / 32'h000F_0000, each after 4 cycles.
REQ-034 op=00, A=32'hAAAA_AAAA, B=32'h5555_5555, out_ready held 0 for 5 cycles -> result=0 held stable, zero=1, in_ready=0 throughout, retire on out_ready.
REQ-035 Accept, then change A/B/op and pulse in_valid in BUSY -> result unaffected, second request not accepted until IDLE.
REQ-036 reset_n=0 for one edge in second BUSY cycle -> IDLE, result=0, no out_valid pulse; next request completes normally.
REQ-037 WIDTH=16, SLICE=16, A=16'h00FF, B=16'h0F0F, op=10 -> out_valid 1 cycle after accept, result=16'h0FF0.
